// File: rtl/count_write_ctrl_if.sv
// rtl/count_write_ctrl_if.sv - asynchronous host bus carrying the counter write strobes
interface count_write_ctrl_if;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] data_in;

  modport master (output cs_n, output wr_n, output addr, output data_in);
  modport slave  (input  cs_n, input  wr_n, input  addr, input  data_in);
endinterface

// File: rtl/count_write_ctrl.sv
// rtl/count_write_ctrl.sv - bus write decoder for three counters: control words and count bytes
module count_write_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  count_write_ctrl_if.slave   bus,
  output logic [5:0]          ctrl_word0,
  output logic [5:0]          ctrl_word1,
  output logic [5:0]          ctrl_word2,
  output logic [15:0]         count_val0,
  output logic [15:0]         count_val1,
  output logic [15:0]         count_val2,
  output logic                load0,
  output logic                load1,
  output logic                load2,
  output logic                cw_wr0,
  output logic                cw_wr1,
  output logic                cw_wr2,
  output logic                latch0,
  output logic                latch1,
  output logic                latch2
);

  typedef enum logic {LSB_WAIT = 1'b0, MSB_WAIT = 1'b1} ptr_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   wr_prev_q, wr_prev_d;
  logic                   cs_hold_q, cs_hold_d;
  logic [1:0]             addr_hold_q, addr_hold_d;
  logic [7:0]             data_hold_q, data_hold_d;
  logic [5:0]             ctrl_q [3];
  logic [5:0]             ctrl_d [3];
  logic [15:0]            val_q [3];
  logic [15:0]            val_d [3];
  logic [7:0]             lsb_q [3];
  logic [7:0]             lsb_d [3];
  ptr_e                   ptr_q [3];
  ptr_e                   ptr_d [3];
  logic [2:0]             load_q, load_d, cw_q, cw_d, latch_q, latch_d;

  logic                   wr_s, fall, rise, commit;
  logic [1:0]             sc, rw;
  logic [2:0]             mode_st;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus.wr_n};
    wr_s        = sync_q[SYNC_STAGES-1];
    wr_prev_d   = wr_s;
    fall        = wr_prev_q & ~wr_s;
    rise        = ~wr_prev_q & wr_s;
    commit      = rise & ~cs_hold_q;

    cs_hold_d   = cs_hold_q;
    addr_hold_d = addr_hold_q;
    data_hold_d = data_hold_q;
    if (fall) begin
      cs_hold_d   = bus.cs_n;
      addr_hold_d = bus.addr;
      data_hold_d = bus.data_in;
    end

    for (int i = 0; i < 3; i++) begin
      ctrl_d[i] = ctrl_q[i];
      val_d[i]  = val_q[i];
      lsb_d[i]  = lsb_q[i];
      ptr_d[i]  = ptr_q[i];
    end
    load_d  = '0;
    cw_d    = '0;
    latch_d = '0;

    sc      = data_hold_q[7:6];
    rw      = data_hold_q[5:4];
    // Modes 110/111 alias onto 010/011: clear the top mode bit when both upper bits are set.
    mode_st = {data_hold_q[3] & ~data_hold_q[2], data_hold_q[2:1]};

    if (commit) begin
      if (addr_hold_q == 2'b11) begin
        if (sc != 2'b11) begin
          if (rw == 2'b00) begin
            latch_d[sc] = 1'b1;
          end else begin
            ctrl_d[sc] = {rw, mode_st, data_hold_q[0]};
            cw_d[sc]   = 1'b1;
            ptr_d[sc]  = LSB_WAIT;
            lsb_d[sc]  = 8'h00;
          end
        end
      end else begin
        case (ctrl_q[addr_hold_q][5:4])
          2'b01: begin
            val_d[addr_hold_q]  = {8'h00, data_hold_q};
            load_d[addr_hold_q] = 1'b1;
          end
          2'b10: begin
            val_d[addr_hold_q]  = {data_hold_q, 8'h00};
            load_d[addr_hold_q] = 1'b1;
          end
          2'b11: begin
            if (ptr_q[addr_hold_q] == LSB_WAIT) begin
              lsb_d[addr_hold_q] = data_hold_q;
              ptr_d[addr_hold_q] = MSB_WAIT;
            end else begin
              val_d[addr_hold_q]  = {data_hold_q, lsb_q[addr_hold_q]};
              load_d[addr_hold_q] = 1'b1;
              ptr_d[addr_hold_q]  = LSB_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      wr_prev_q   <= 1'b1;
      cs_hold_q   <= 1'b0;
      addr_hold_q <= 2'b00;
      data_hold_q <= 8'h00;
      for (int i = 0; i < 3; i++) begin
        ctrl_q[i] <= 6'h00;
        val_q[i]  <= 16'h0000;
        lsb_q[i]  <= 8'h00;
        ptr_q[i]  <= LSB_WAIT;
      end
      load_q  <= '0;
      cw_q    <= '0;
      latch_q <= '0;
    end else begin
      sync_q      <= sync_d;
      wr_prev_q   <= wr_prev_d;
      cs_hold_q   <= cs_hold_d;
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
      for (int i = 0; i < 3; i++) begin
        ctrl_q[i] <= ctrl_d[i];
        val_q[i]  <= val_d[i];
        lsb_q[i]  <= lsb_d[i];
        ptr_q[i]  <= ptr_d[i];
      end
      load_q  <= load_d;
      cw_q    <= cw_d;
      latch_q <= latch_d;
    end
  end

  assign ctrl_word0 = ctrl_q[0];
  assign ctrl_word1 = ctrl_q[1];
  assign ctrl_word2 = ctrl_q[2];
  assign count_val0 = val_q[0];
  assign count_val1 = val_q[1];
  assign count_val2 = val_q[2];
  assign {load2, load1, load0}    = load_q;
  assign {cw_wr2, cw_wr1, cw_wr0} = cw_q;
  assign {latch2, latch1, latch0} = latch_q;

endmodule

// File: tb/tb_count_write_ctrl.sv
// tb/tb_count_write_ctrl.sv - directed bench for count_write_ctrl with a rule-level model
module tb_count_write_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  count_write_ctrl_if bus ();

  logic [5:0]  ctrl_word0, ctrl_word1, ctrl_word2;
  logic [15:0] count_val0, count_val1, count_val2;
  logic        load0, load1, load2, cw_wr0, cw_wr1, cw_wr2, latch0, latch1, latch2;

  count_write_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ctrl_word0(ctrl_word0), .ctrl_word1(ctrl_word1), .ctrl_word2(ctrl_word2),
    .count_val0(count_val0), .count_val1(count_val1), .count_val2(count_val2),
    .load0(load0), .load1(load1), .load2(load2),
    .cw_wr0(cw_wr0), .cw_wr1(cw_wr1), .cw_wr2(cw_wr2),
    .latch0(latch0), .latch1(latch1), .latch2(latch2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Rule-level model of the programmed state, updated once per completed bus write.
  logic [5:0]  m_ctrl [3];
  logic [15:0] m_val  [3];
  logic [7:0]  m_lsb  [3];
  bit          m_pend [3];
  int          e_load [3], e_cw [3], e_latch [3];
  int          n_load [3], n_cw [3], n_latch [3];
  bit          quiet = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ctrl[i] = 6'h00; m_val[i] = 16'h0000; m_lsb[i] = 8'h00; m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_write(input bit cs, input int a, input logic [7:0] d);
    int sc, rw, mode;
    for (int i = 0; i < 3; i++) begin
      e_load[i] = 0; e_cw[i] = 0; e_latch[i] = 0;
    end
    if (cs) return;
    if (a == 3) begin
      sc = int'(d[7:6]);
      rw = int'(d[5:4]);
      if (sc == 3) return;
      if (rw == 0) begin
        e_latch[sc] = 1;
      end else begin
        mode = int'(d[3:1]);
        if (mode >= 6) mode = mode - 4;
        m_ctrl[sc]  = {d[5:4], 3'(mode), d[0]};
        m_pend[sc]  = 1'b0;
        e_cw[sc]    = 1;
      end
    end else begin
      rw = int'(m_ctrl[a][5:4]);
      if (rw == 1) begin
        m_val[a] = 16'(d); e_load[a] = 1;
      end else if (rw == 2) begin
        m_val[a] = 16'(d) * 256; e_load[a] = 1;
      end else if (rw == 3) begin
        if (!m_pend[a]) begin
          m_lsb[a] = d; m_pend[a] = 1'b1;
        end else begin
          m_val[a] = 16'(d) * 256 + 16'(m_lsb[a]); m_pend[a] = 1'b0; e_load[a] = 1;
        end
      end
    end
  endtask

  task automatic bus_write(input bit cs, input logic [1:0] a, input logic [7:0] d);
    int b_load [3], b_cw [3], b_latch [3];
    quiet = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_load[i] = n_load[i]; b_cw[i] = n_cw[i]; b_latch[i] = n_latch[i];
    end
    @(posedge clk); #2;
    bus.cs_n = cs; bus.addr = a; bus.data_in = d; bus.wr_n = 1'b0;
    repeat (8) @(posedge clk);
    #2 bus.wr_n = 1'b1;
    repeat (8) @(posedge clk);
    #2 bus.cs_n = 1'b1;
    model_write(cs, int'(a), d);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("load%0d_pulses", i),  64'(n_load[i] - b_load[i]),   64'(e_load[i]));
      chk($sformatf("cw_wr%0d_pulses", i), 64'(n_cw[i] - b_cw[i]),       64'(e_cw[i]));
      chk($sformatf("latch%0d_pulses", i), 64'(n_latch[i] - b_latch[i]), 64'(e_latch[i]));
    end
    quiet = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {ctrl_word0, ctrl_word1, ctrl_word2}, 64'h0);
    chk({tag, "_val"},  {count_val0, count_val1, count_val2}, 64'h0);
    chk({tag, "_pulses"}, {load0, load1, load2, cw_wr0, cw_wr1, cw_wr2, latch0, latch1, latch2}, 64'h0);
  endtask

  // Per-cycle compare: pulse accounting, exclusivity, load-gated value changes, idle state vs model.
  logic [15:0] pv [3];
  bit          prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_load[0]  += int'(load0);  n_load[1]  += int'(load1);  n_load[2]  += int'(load2);
      n_cw[0]    += int'(cw_wr0); n_cw[1]    += int'(cw_wr1); n_cw[2]    += int'(cw_wr2);
      n_latch[0] += int'(latch0); n_latch[1] += int'(latch1); n_latch[2] += int'(latch2);
      chk("pulse_onehot", 64'($onehot0({load0, load1, load2, cw_wr0, cw_wr1, cw_wr2, latch0, latch1, latch2})), 64'd1);
      if (prev_valid) begin
        if (count_val0 !== pv[0]) chk("val0_change_has_load", 64'(load0), 64'd1);
        if (count_val1 !== pv[1]) chk("val1_change_has_load", 64'(load1), 64'd1);
        if (count_val2 !== pv[2]) chk("val2_change_has_load", 64'(load2), 64'd1);
      end
      if (quiet) begin
        chk("idle_ctrl", {ctrl_word0, ctrl_word1, ctrl_word2}, {m_ctrl[0], m_ctrl[1], m_ctrl[2]});
        chk("idle_val",  {count_val0, count_val1, count_val2}, {m_val[0], m_val[1], m_val[2]});
      end
    end
    prev_valid = (rst_n === 1'b1);
    pv[0] = count_val0; pv[1] = count_val1; pv[2] = count_val2;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b_ld;
    for (int i = 0; i < 3; i++) begin
      n_load[i] = 0; n_cw[i] = 0; n_latch[i] = 0;
    end
    model_reset();
    rst_n = 1'b0;
    bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.addr = 2'b00; bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #2 chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 quiet = 1'b1;

    // Unprogrammed counter, deselected write, read-back command: nothing moves.
    bus_write(1'b0, 2'b00, 8'h55);
    bus_write(1'b1, 2'b11, 8'h30);
    bus_write(1'b0, 2'b11, 8'hC0);
    chk("noop_ctrl0", 64'(ctrl_word0), 64'h00);
    chk("noop_val0",  64'(count_val0), 64'h0000);

    bus_write(1'b0, 2'b11, 8'h30);
    bus_write(1'b0, 2'b00, 8'h34);
    chk("lsb_hidden_val0", 64'(count_val0), 64'h0000);
    bus_write(1'b0, 2'b00, 8'h12);
    chk("ctrl0_30", 64'(ctrl_word0), 64'h30);
    chk("val0_1234", 64'(count_val0), 64'h1234);

    bus_write(1'b0, 2'b11, 8'h54);
    bus_write(1'b0, 2'b01, 8'hAB);
    chk("ctrl1_14", 64'(ctrl_word1), 64'h14);
    chk("val1_00ab", 64'(count_val1), 64'h00AB);

    bus_write(1'b0, 2'b11, 8'hB0);
    bus_write(1'b0, 2'b10, 8'h11);
    bus_write(1'b0, 2'b11, 8'hB0);
    bus_write(1'b0, 2'b10, 8'h22);
    bus_write(1'b0, 2'b10, 8'h33);
    chk("val2_3322", 64'(count_val2), 64'h3322);
    chk("ctrl2_30", 64'(ctrl_word2), 64'h30);
    chk("val0_untouched", 64'(count_val0), 64'h1234);

    bus_write(1'b0, 2'b11, 8'h00);
    chk("latch_ctrl0", 64'(ctrl_word0), 64'h30);
    chk("latch_val0", 64'(count_val0), 64'h1234);

    bus_write(1'b0, 2'b11, 8'hBE);
    chk("ctrl2_mode111", 64'(ctrl_word2), 64'h36);
    bus_write(1'b0, 2'b11, 8'hA0);
    bus_write(1'b0, 2'b10, 8'hC5);
    chk("val2_c500", 64'(count_val2), 64'hC500);
    bus_write(1'b0, 2'b01, 8'h00);
    chk("val1_zero", 64'(count_val1), 64'h0000);

    bus_write(1'b0, 2'b11, 8'h3C);
    chk("ctrl0_mode110", 64'(ctrl_word0), 64'h34);
    bus_write(1'b0, 2'b00, 8'h77);

    // Asynchronous reset while counter 0 holds an LSB.
    quiet = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    b_ld = n_load[0];
    repeat (10) @(posedge clk);
    #2 chk("no_load_after_release", 64'(n_load[0] - b_ld), 64'd0);
    model_reset();
    quiet = 1'b1;
    bus_write(1'b0, 2'b11, 8'h30);
    bus_write(1'b0, 2'b00, 8'h78);
    bus_write(1'b0, 2'b00, 8'h9A);
    chk("val0_9a78", 64'(count_val0), 64'h9A78);

    // Write whose rising edge falls inside reset is dropped.
    bus_write(1'b0, 2'b11, 8'h10);
    quiet = 1'b0;
    b_ld = n_load[0];
    @(posedge clk); #2;
    bus.cs_n = 1'b0; bus.addr = 2'b00; bus.data_in = 8'h55; bus.wr_n = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #10 bus.wr_n = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b1;
    bus.cs_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    model_reset();
    chk("rst_write_no_load", 64'(n_load[0] - b_ld), 64'd0);
    chk("rst_write_val0", 64'(count_val0), 64'h0000);
    chk("rst_write_ctrl0", 64'(ctrl_word0), 64'h00);
    quiet = 1'b1;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
